// File: rtl/regfile_dump_reader_if.sv
// Core-side bus of the register bank: write port, two read ports and the dump stream.
// The master drives requests and the bank (slave) returns read data and dump beats.
interface regfile_dump_reader_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            rs1_en;
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic            rs2_en;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            dump_start;
    logic            dump_busy;
    logic            dump_valid;
    logic            dump_ready;
    logic [AW-1:0]   dump_idx;
    logic [XLEN-1:0] dump_data;

    modport master (
        output we, waddr, wdata,
        output rs1_en, rs1_addr, rs2_en, rs2_addr,
        output dump_start, dump_ready,
        input  rs1_data, rs2_data,
        input  dump_busy, dump_valid, dump_idx, dump_data
    );

    modport slave (
        input  we, waddr, wdata,
        input  rs1_en, rs1_addr, rs2_en, rs2_addr,
        input  dump_start, dump_ready,
        output rs1_data, rs2_data,
        output dump_busy, dump_valid, dump_idx, dump_data
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// RISC-V register bank with two registered, write-bypassed read ports and a
// serial dump engine that streams every register out over valid/ready.
module regfile_dump_reader #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input logic                  clk,
    input logic                  rst,
    regfile_dump_reader_if.slave bus
);
    typedef enum logic {IDLE, SEND} dump_state_t;

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0] rs1_next, rs2_next;

    dump_state_t     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d, idx_inc;
    logic [XLEN-1:0] data_q, data_d, dump_next;

    // x0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.we && (bus.waddr != '0)) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Same-cycle write wins over the stored value so readers see the new data
    assign rs1_next = (bus.rs1_addr == '0) ? '0 :
                      (bus.we && (bus.waddr == bus.rs1_addr)) ? bus.wdata :
                      regs[bus.rs1_addr];
    assign rs2_next = (bus.rs2_addr == '0) ? '0 :
                      (bus.we && (bus.waddr == bus.rs2_addr)) ? bus.wdata :
                      regs[bus.rs2_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            if (bus.rs1_en) begin
                rs1_q <= rs1_next;
            end
            if (bus.rs2_en) begin
                rs2_q <= rs2_next;
            end
        end
    end

    assign bus.rs1_data = rs1_q;
    assign bus.rs2_data = rs2_q;

    assign idx_inc   = idx_q + AW'(1);
    assign dump_next = (idx_inc == '0) ? '0 :
                       (bus.we && (bus.waddr == idx_inc)) ? bus.wdata :
                       regs[idx_inc];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // A beat is a snapshot: data only changes when a new beat is loaded
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (bus.dump_start) begin
                    state_d = SEND;
                    idx_d   = '0;
                    data_d  = '0;
                end
            end
            SEND: begin
                if (bus.dump_ready) begin
                    if (idx_q == AW'(NREG - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = dump_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dump_busy  = (state_q == SEND);
    assign bus.dump_valid = (state_q == SEND);
    assign bus.dump_idx   = idx_q;
    assign bus.dump_data  = data_q;
endmodule
